fpu_int_to_float: RTL



---
 rtl/fpu_pkg.sv | 16 +
 rtl/count_leading_zeros.sv | 25 ++
 rtl/fpu_int_to_float.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision field widths and the
// int-to-float conversion state encoding.
package fpu_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int INT_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_e;

endpackage

// File: rtl/count_leading_zeros.sv
// Combinational leading-zero counter over a 2**BITS wide word.
// o_zero flags an all-zero input; o_count is 0 in that case.
module count_leading_zeros #(
  parameter int BITS = 5
) (
  input  logic [(1<<BITS)-1:0] i_data,
  output logic [BITS-1:0]      o_count,
  output logic                 o_zero
);

  localparam int W = 1 << BITS;

  // Scan upward so the most significant set bit is the last one to assign.
  always_comb begin
    o_count = '0;
    o_zero  = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) begin
        o_count = BITS'(W - 1 - i);
        o_zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fpu_int_to_float.sv
// 32-bit integer (signed or unsigned) to IEEE-754 single conversion with
// round-to-nearest-even, sequenced IDLE -> NORM -> ROUND over one shared
// leading-zero counter.
//
// Handshake: start is sampled only on a rising edge where ready=1 (state
// IDLE); a start at any other time is dropped. done pulses for exactly one
// cycle when result/inexact take their new value, and that done cycle is
// also an IDLE cycle, so a new start there is accepted.
module fpu_int_to_float
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        inexact,
  output logic [1:0]  dbg_state
);

  localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_BIAS + INT_W - 1);

  state_e                r_state;
  logic                  r_ready;
  logic                  r_done;
  logic [31:0]           r_result;
  logic                  r_inexact;
  logic                  r_sign;
  logic [INT_W-1:0]      r_mag;
  logic [4:0]            r_lz;
  logic                  r_zero;
  logic [INT_W-1:0]      r_shifted;

  logic                  w_neg;
  logic [INT_W-1:0]      w_mag;
  logic [4:0]            w_lz;
  logic                  w_zero;
  logic [INT_W-1:0]      w_shifted;
  logic [FP_MANT_W-1:0]  w_mant;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_round_up;
  logic [FP_MANT_W:0]    w_mant_inc;
  logic                  w_carry;
  logic [FP_EXP_W-1:0]   w_exp;
  logic [31:0]           w_result;
  logic                  w_inexact;
  logic                  w_unused;

  // Operand capture: magnitude in 32 bits, so -2^31 maps to 0x80000000.
  assign w_neg = is_signed & a[31];
  assign w_mag = w_neg ? (~a + 32'd1) : a;

  count_leading_zeros #(.BITS(5)) u_clz (
    .i_data  (r_mag),
    .o_count (w_lz),
    .o_zero  (w_zero)
  );

  assign w_shifted = r_mag << w_lz;

  // Rounding from the normalized word; bit 31 is the implicit leading one.
  assign w_mant     = r_shifted[30:8];
  assign w_guard    = r_shifted[7];
  assign w_sticky   = |r_shifted[6:0];
  assign w_round_up = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_inc = {1'b0, w_mant} + {{FP_MANT_W{1'b0}}, w_round_up};
  assign w_carry    = w_mant_inc[FP_MANT_W];
  assign w_exp      = EXP_TOP - {3'b000, r_lz} + {{(FP_EXP_W-1){1'b0}}, w_carry};
  assign w_inexact  = r_zero ? 1'b0 : (w_guard | w_sticky);
  assign w_result   = r_zero ? 32'h0000_0000
                             : {r_sign, w_exp, w_carry ? {FP_MANT_W{1'b0}} : w_mant_inc[FP_MANT_W-1:0]};

  // The leading one is implied by normalization and never read directly.
  assign w_unused = r_shifted[31];

  // Conversion sequencer with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_inexact <= 1'b0;
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_lz      <= '0;
      r_zero    <= 1'b0;
      r_shifted <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sign  <= w_neg;
            r_mag   <= w_mag;
            r_ready <= 1'b0;
            r_state <= NORM;
          end
        end
        NORM: begin
          r_lz      <= w_lz;
          r_zero    <= w_zero;
          r_shifted <= w_shifted;
          r_state   <= ROUND;
        end
        ROUND: begin
          r_result  <= w_result;
          r_inexact <= w_inexact;
          r_done    <= 1'b1;
          r_ready   <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign result    = r_result;
  assign inexact   = r_inexact;
  assign dbg_state = r_state;

endmodule
